// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the load/store path: RISC-V funct3 access size
// codes, the LSU state type, and a helper that says whether a funct3 code
// is a load/store size the LSU supports.
package riscv_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic {
    LSU_IDLE,
    LSU_WAIT
  } lsu_state_t;

  // Codes 3, 6 and 7 have no load/store meaning and are never issued.
  function automatic logic size_is_legal(input logic [2:0] size);
    logic legal;
    case (size)
      LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU: legal = 1'b1;
      default:                                  legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align
// Combinational load data extraction. It picks the addressed byte or
// halfword out of the memory word and sign- or zero-extends it to 32 bits.
// Ports:
//   mem_rd_i  : 32-bit word returned by the data memory
//   offset_i  : byte offset of the access within the word (latched)
//   size_i    : funct3 size code of the access (latched)
//   load_o    : extended load result; 0 for codes that are not loads
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] mem_rd_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  size_i,
  output logic [31:0] load_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_rd_i[8*offset_i +: 8];
    half_sel = mem_rd_i[16*offset_i[1] +: 16];
    load_o   = 32'd0;
    case (size_i)
      LDST_B:  load_o = {{24{byte_sel[7]}}, byte_sel};
      LDST_H:  load_o = {{16{half_sel[15]}}, half_sel};
      LDST_W:  load_o = mem_rd_i;
      LDST_BU: load_o = {24'd0, byte_sel};
      LDST_HU: load_o = {16'd0, half_sel};
      default: load_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu
// Load/store unit between the memory-access stage and the data memory.
// A legal, aligned request is issued to memory in IDLE and the core is
// stalled for that cycle; the following WAIT cycle collects the read data
// (or just lets a store retire) and releases the core once memory is ready.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   core_req_i/we_i       : access request and store (1) / load (0)
//   core_size_i           : funct3 size code
//   core_addr_i, core_wd_i: byte address and right-aligned store data
//   core_rd_o             : extended load result, valid as stall falls
//   core_stall_o          : core must hold its request and PC
//   misalign_o            : misaligned access seen this cycle
//   mem_req_o/we_o/be_o   : memory request, write enable, byte enables
//   mem_addr_o, mem_wd_o  : word-aligned address, lane-replicated data
//   mem_rd_i, mem_ready_i : registered read data and completion flag
module riscv_lsu
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  lsu_state_t  state_q, state_d;
  logic [1:0]  offset_q, offset_d;
  logic [2:0]  size_q, size_d;
  logic        we_q, we_d;

  logic        size_legal;
  logic        addr_misaligned;
  logic [31:0] load_data;

  lsu_load_align u_load_align (
    .mem_rd_i (mem_rd_i),
    .offset_i (offset_q),
    .size_i   (size_q),
    .load_o   (load_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= LSU_IDLE;
      offset_q <= 2'd0;
      size_q   <= 3'd0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      size_q   <= size_d;
      we_q     <= we_d;
    end
  end

  // Illegal size codes are filtered out before the alignment test so that
  // code 6 (whose low bits look like a word) never raises misalign_o.
  always_comb begin
    size_legal      = size_is_legal(core_size_i);
    addr_misaligned = ((core_size_i[1:0] == 2'd1) & core_addr_i[0]) |
                      ((core_size_i[1:0] == 2'd2) & (core_addr_i[1:0] != 2'd0));

    state_d      = state_q;
    offset_d     = offset_q;
    size_d       = size_q;
    we_d         = we_q;
    core_rd_o    = 32'd0;
    core_stall_o = 1'b0;
    misalign_o   = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'b0000;
    mem_addr_o   = 32'd0;
    mem_wd_o     = 32'd0;

    case (state_q)
      LSU_IDLE: begin
        if (core_req_i && size_legal) begin
          if (addr_misaligned) begin
            misalign_o = 1'b1;
          end else begin
            mem_req_o    = 1'b1;
            mem_we_o     = core_we_i;
            mem_addr_o   = {core_addr_i[31:2], 2'b00};
            core_stall_o = 1'b1;
            case (core_size_i[1:0])
              2'd0: begin
                mem_be_o = 4'b0001 << core_addr_i[1:0];
                mem_wd_o = {4{core_wd_i[7:0]}};
              end
              2'd1: begin
                mem_be_o = 4'b0011 << {core_addr_i[1], 1'b0};
                mem_wd_o = {2{core_wd_i[15:0]}};
              end
              default: begin
                mem_be_o = 4'b1111;
                mem_wd_o = core_wd_i;
              end
            endcase
            offset_d = core_addr_i[1:0];
            size_d   = core_size_i;
            we_d     = core_we_i;
            state_d  = LSU_WAIT;
          end
        end
      end
      LSU_WAIT: begin
        // The WAIT cycle always runs to completion, even if the core has
        // dropped its request; stores return 0 on the read port.
        if (mem_ready_i) begin
          state_d = LSU_IDLE;
          if (!we_q) begin
            core_rd_o = load_data;
          end
        end else begin
          core_stall_o = 1'b1;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu
// Self-checking bench for riscv_lsu: directed cases followed by random
// transactions compared against a byte-lane reference model.
module tb_riscv_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        misalign_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  int assertCount = 0;
  int failCount   = 0;

  riscv_lsu dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .misalign_o   (misalign_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .mem_ready_i  (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference model: access width in bytes from the funct3 code.
  function automatic int accessBytes(input logic [2:0] size);
    case (size)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit sizeLegal(input logic [2:0] size);
    return (size == 3'd0) || (size == 3'd1) || (size == 3'd2) ||
           (size == 3'd4) || (size == 3'd5);
  endfunction

  function automatic logic [3:0] modelBe(input logic [2:0] size, input logic [31:0] addr);
    int n = accessBytes(size);
    int off = int'(addr % 4);
    int be = ((1 << n) - 1) << off;
    return be[3:0];
  endfunction

  // Each memory lane i carries store byte (i mod width).
  function automatic logic [31:0] modelWd(input logic [2:0] size, input logic [31:0] wd);
    int n = accessBytes(size);
    logic [31:0] res = 32'd0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] b;
      b = (wd >> (8 * (i % n))) & 32'hFF;
      res = res | (b << (8 * i));
    end
    return res;
  endfunction

  function automatic logic [31:0] modelRd(input logic [2:0] size, input logic [31:0] addr,
                                          input logic [31:0] word);
    int n = accessBytes(size);
    logic [31:0] v = word >> (8 * (addr % 4));
    logic [31:0] mask;
    if (n == 4) return word;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = v & mask;
    if (size < 3'd4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic checkIdleQuiet(input string tag);
    checkOutput({tag, ".rd"},    core_rd_o, 32'd0);
    checkOutput({tag, ".ctl"},   {28'd0, core_stall_o, misalign_o, mem_req_o, mem_we_o}, 32'd0);
    checkOutput({tag, ".be"},    {28'd0, mem_be_o}, 32'd0);
    checkOutput({tag, ".addr"},  mem_addr_o, 32'd0);
    checkOutput({tag, ".wd"},    mem_wd_o, 32'd0);
  endtask

  // Presents one request starting just after a rising edge, then runs the
  // WAIT phase with waitCycles of mem_ready_i=0 before completing.
  task automatic applyStimulus(input string tag, input logic we, input logic [2:0] size,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] word, input int waitCycles);
    bit legal = sizeLegal(size);
    bit aligned = (addr % accessBytes(size)) == 0;
    bit issue = legal && aligned;
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    mem_ready_i = 1'b1;
    mem_rd_i    = $urandom;
    #2;
    checkOutput({tag, ".misalign"}, {31'd0, misalign_o}, {31'd0, legal && !aligned});
    checkOutput({tag, ".req"},      {31'd0, mem_req_o},  {31'd0, issue});
    checkOutput({tag, ".stall0"},   {31'd0, core_stall_o}, {31'd0, issue});
    checkOutput({tag, ".rd0"},      core_rd_o, 32'd0);
    if (issue) begin
      checkOutput({tag, ".we"},   {31'd0, mem_we_o}, {31'd0, we});
      checkOutput({tag, ".be"},   {28'd0, mem_be_o}, {28'd0, modelBe(size, addr)});
      checkOutput({tag, ".addr"}, mem_addr_o, addr & ~32'd3);
      checkOutput({tag, ".wd"},   mem_wd_o, modelWd(size, wd));
    end else begin
      checkOutput({tag, ".be0"},  {28'd0, mem_be_o}, 32'd0);
    end
    @(posedge clk_i); #1;
    if (issue) begin
      for (int i = 0; i < waitCycles; i++) begin
        mem_ready_i = 1'b0;
        mem_rd_i    = $urandom;
        #2;
        checkOutput({tag, ".stallW"}, {31'd0, core_stall_o}, 32'd1);
        checkOutput({tag, ".reqW"},   {27'd0, mem_req_o, mem_be_o}, 32'd0);
        @(posedge clk_i); #1;
      end
      mem_ready_i = 1'b1;
      mem_rd_i    = word;
      #2;
      checkOutput({tag, ".stall1"}, {31'd0, core_stall_o}, 32'd0);
      checkOutput({tag, ".reqW"},   {27'd0, mem_req_o, mem_be_o}, 32'd0);
      checkOutput({tag, ".rd"},     core_rd_o, we ? 32'd0 : modelRd(size, addr, word));
      @(posedge clk_i); #1;
    end
    core_req_i = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b1;
    core_req_i  = 1'b0;
    core_we_i   = 1'b0;
    core_size_i = 3'd0;
    core_addr_i = 32'd0;
    core_wd_i   = 32'd0;
    mem_rd_i    = 32'd0;
    mem_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #2;
    checkIdleQuiet("reset");

    applyStimulus("lw",  1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    applyStimulus("lb",  1'b0, 3'd0, 32'h13, 32'h0, 32'hDEADBEEF, 0);
    applyStimulus("lbu", 1'b0, 3'd4, 32'h13, 32'h0, 32'hDEADBEEF, 0);
    applyStimulus("lh",  1'b0, 3'd1, 32'h12, 32'h0, 32'hDEADBEEF, 0);
    applyStimulus("lhu", 1'b0, 3'd5, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    applyStimulus("sb",  1'b1, 3'd0, 32'h21, 32'h12345678, 32'h0, 0);
    applyStimulus("sh",  1'b1, 3'd1, 32'h22, 32'h12345678, 32'h0, 0);
    applyStimulus("mislw", 1'b0, 3'd2, 32'h02, 32'h0, 32'h0, 0);
    applyStimulus("missh", 1'b1, 3'd1, 32'h05, 32'h0, 32'h0, 0);
    applyStimulus("ill6",  1'b0, 3'd6, 32'h03, 32'h0, 32'h0, 0);
    applyStimulus("waitlw", 1'b0, 3'd2, 32'h40, 32'h0, 32'hCAFEF00D, 3);
    #2;
    checkIdleQuiet("idle");

    // Reset pulsed while the LSU is waiting on memory.
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = 3'd2;
    core_addr_i = 32'h80;
    mem_ready_i = 1'b1;
    @(posedge clk_i); #1;
    mem_ready_i = 1'b0;
    rst_i       = 1'b1;
    #2;
    checkOutput("rstw.stall", {31'd0, core_stall_o}, 32'd1);
    @(posedge clk_i); #1;
    rst_i       = 1'b0;
    core_req_i  = 1'b0;
    mem_ready_i = 1'b1;
    #2;
    checkIdleQuiet("rstw.after");
    @(posedge clk_i); #1;
    applyStimulus("rstlw", 1'b0, 3'd2, 32'h0, 32'h0, 32'h13579BDF, 0);

    // Random traffic; sometimes back-to-back, sometimes with an idle gap.
    for (int t = 0; t < 300; t++) begin
      logic [2:0]  sz;
      logic [31:0] ad;
      sz = 3'($urandom_range(0, 7));
      ad = $urandom;
      if ($urandom_range(0, 3) != 0) ad[1:0] = ad[1:0] & ((sz[1:0] == 2'd2) ? 2'b00 :
                                                          (sz[1:0] == 2'd1) ? 2'b10 : 2'b11);
      applyStimulus("rnd", 1'($urandom_range(0, 1)), sz, ad, $urandom, $urandom,
                    $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        #2;
        checkIdleQuiet("rndidle");
        @(posedge clk_i); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
